// File: rtl/ir_fan_controller.sv
// ir_fan_controller
//   Command sequencer for the IR remote fan. Validates decoded NEC frames,
//   runs the power / speed / off-timer state machine, drives the fan PWM and
//   produces the 4-digit FND value (speed level or remaining mm:ss in BCD).
//
// Ports
//   clk          system clock
//   reset_p      asynchronous active-high reset
//   ir_valid     one-clk pulse: new frame on ir_data
//   ir_data      [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
//   fan_pwm      registered fan drive
//   speed_level  0 = off, 1..3 = running level
//   timer_active off-timer running
//   disp_value   FND value, 4 hex/BCD digits
//   key_ok       one-clk pulse: accepted frame
//   frame_error  one-clk pulse: rejected frame
module ir_fan_controller #(
  parameter int unsigned PWM_PERIOD = 4000,
  parameter int unsigned TICK_1S    = 100_000_000,
  parameter logic [7:0]  DEV_ADDR   = 8'h00,
  parameter logic [7:0]  KEY_POWER  = 8'h45,
  parameter logic [7:0]  KEY_SPEED  = 8'h46,
  parameter logic [7:0]  KEY_TIMER  = 8'h47
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        ir_valid,
  input  logic [31:0] ir_data,
  output logic        fan_pwm,
  output logic [1:0]  speed_level,
  output logic        timer_active,
  output logic [15:0] disp_value,
  output logic        key_ok,
  output logic        frame_error
);

  localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
  localparam int unsigned PW = (TICK_1S > 1) ? $clog2(TICK_1S) : 1;

  localparam logic [CW-1:0] PWM_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DUTY_1   = CW'(PWM_PERIOD / 4);
  localparam logic [CW-1:0] DUTY_2   = CW'(PWM_PERIOD / 2);
  localparam logic [CW-1:0] DUTY_3   = CW'(PWM_PERIOD);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_1S - 1);

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    speed_q, speed_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] duty_q;
  logic [CW-1:0] duty_eff;
  logic          fan_pwm_q;
  logic          key_ok_q;
  logic          frame_error_q;

  logic       frame_ok;
  logic       accept;
  logic [7:0] cmd;
  logic       timer_on;
  logic       tick;
  logic       expire;

  // mm:ss down-count with borrow; seconds tens digit wraps 0 -> 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  function automatic logic [CW-1:0] duty_for(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return DUTY_1;
      2'd2:    return DUTY_2;
      2'd3:    return DUTY_3;
      default: return '0;
    endcase
  endfunction

  assign frame_ok = (ir_data[15:8]  == ~ir_data[7:0])   &&
                    (ir_data[31:24] == ~ir_data[23:16]) &&
                    (ir_data[7:0]   == DEV_ADDR);
  assign accept   = ir_valid && frame_ok;
  assign cmd      = ir_data[23:16];
  assign timer_on = (idx_q != 2'd0);
  assign tick     = timer_on && (presc_q == PRESC_LAST);
  assign expire   = tick && (bcd_q == 16'h0001);

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    idx_d   = idx_q;
    bcd_d   = bcd_q;
    presc_d = timer_on ? (tick ? '0 : presc_q + PW'(1)) : '0;

    if (tick) begin
      bcd_d = bcd_dec(bcd_q);
    end

    if (expire) begin
      state_d = ST_OFF;
      speed_d = 2'd0;
      idx_d   = 2'd0;
      bcd_d   = '0;
      presc_d = '0;
    end

    // POWER overrides a coincident expiry; any other command loses to it.
    if (accept) begin
      if (cmd == KEY_POWER) begin
        idx_d   = 2'd0;
        bcd_d   = '0;
        presc_d = '0;
        if (state_q == ST_OFF) begin
          state_d = ST_RUN;
          speed_d = 2'd1;
        end else begin
          state_d = ST_OFF;
          speed_d = 2'd0;
        end
      end else if (!expire && state_q == ST_RUN) begin
        if (cmd == KEY_SPEED) begin
          speed_d = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
        end else if (cmd == KEY_TIMER) begin
          idx_d   = idx_q + 2'd1;
          presc_d = '0;
          case (idx_q + 2'd1)
            2'd1:    bcd_d = 16'h0100;
            2'd2:    bcd_d = 16'h0300;
            2'd3:    bcd_d = 16'h0500;
            default: bcd_d = 16'h0000;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q       <= ST_OFF;
      speed_q       <= '0;
      idx_q         <= '0;
      bcd_q         <= '0;
      presc_q       <= '0;
      key_ok_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      speed_q       <= speed_d;
      idx_q         <= idx_d;
      bcd_q         <= bcd_d;
      presc_q       <= presc_d;
      key_ok_q      <= accept;
      frame_error_q <= ir_valid && !frame_ok;
    end
  end

  // At a period start the freshly selected duty applies to that same cycle.
  assign duty_eff = (cnt_q == '0) ? duty_for(speed_q) : duty_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q     <= '0;
      duty_q    <= '0;
      fan_pwm_q <= 1'b0;
    end else begin
      if (state_q == ST_RUN) begin
        cnt_q <= (cnt_q == PWM_LAST) ? '0 : cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      if (cnt_q == '0) begin
        duty_q <= duty_for(speed_q);
      end
      // Looking at state_d drops the drive on the edge that leaves RUN.
      fan_pwm_q <= (state_q == ST_RUN) && (state_d == ST_RUN) && (cnt_q < duty_eff);
    end
  end

  assign fan_pwm      = fan_pwm_q;
  assign speed_level  = speed_q;
  assign timer_active = timer_on;
  assign key_ok       = key_ok_q;
  assign frame_error  = frame_error_q;

  always_comb begin
    disp_value = '0;
    if (state_q == ST_RUN) begin
      disp_value = timer_on ? bcd_q : {14'h0000, speed_q};
    end
  end

endmodule

// File: tb/tb_ir_fan_controller.sv
// tb_ir_fan_controller
//   Directed bench for ir_fan_controller with small simulation parameters.
//   Expected values are queued when stimulus is applied and popped at the
//   negative clock edge where the DUT result is sampled.
module tb_ir_fan_controller;

  localparam logic [31:0] F_POWER = 32'hBA45FF00;
  localparam logic [31:0] F_SPEED = 32'hB946FF00;
  localparam logic [31:0] F_TIMER = 32'hB847FF00;
  localparam logic [31:0] F_BADCK = 32'hBA44FF00;
  localparam logic [31:0] F_BADAD = 32'hBA45FE01;
  localparam logic [31:0] F_UNKN  = 32'hEF10FF00;

  logic        clk;
  logic        reset_p;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic        fan_pwm;
  logic [1:0]  speed_level;
  logic        timer_active;
  logic [15:0] disp_value;
  logic        key_ok;
  logic        frame_error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  ir_fan_controller #(
    .PWM_PERIOD(8),
    .TICK_1S   (10),
    .DEV_ADDR  (8'h00)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .fan_pwm     (fan_pwm),
    .speed_level (speed_level),
    .timer_active(timer_active),
    .disp_value  (disp_value),
    .key_ok      (key_ok),
    .frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // Drive one frame; returns at the negedge right after the sampling edge.
  task automatic send(input string tag, input logic [31:0] d,
                      input logic ok, input logic err);
    push({tag, "_pulse"}, {30'd0, ok, err});
    @(negedge clk);
    ir_valid = 1'b1;
    ir_data  = d;
    @(negedge clk);
    ir_valid = 1'b0;
    ir_data  = '0;
    check({30'd0, key_ok, frame_error});
  endtask

  task automatic check_state(input string tag, input logic [1:0] spd,
                             input logic ta, input logic [15:0] disp);
    push({tag, "_speed"}, {30'd0, spd});
    push({tag, "_timer"}, {31'd0, ta});
    push({tag, "_disp"},  {16'd0, disp});
    check({30'd0, speed_level});
    check({31'd0, timer_active});
    check({16'd0, disp_value});
  endtask

  task automatic check_pwm(input string tag, input int unsigned highs_exp);
    int unsigned highs;
    highs = 0;
    push(tag, highs_exp);
    repeat (16) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fan_pwm) highs++;
    end
    check(highs);
  endtask

  initial begin
    reset_p  = 1'b1;
    ir_valid = 1'b0;
    ir_data  = '0;
    repeat (3) @(negedge clk);
    check_state("reset", 2'd0, 1'b0, 16'h0000);
    push("reset_pwm", 32'd0);
    check({31'd0, fan_pwm});
    push("reset_pulses", 32'd0);
    check({30'd0, key_ok, frame_error});
    reset_p = 1'b0;
    repeat (2) @(negedge clk);

    // Power on and speed stepping
    send("power_on", F_POWER, 1'b1, 1'b0);
    check_state("power_on", 2'd1, 1'b0, 16'h0001);
    push("key_ok_one_cycle", 32'd0);
    @(negedge clk);
    check({31'd0, key_ok});
    check_pwm("pwm_lvl1", 2);
    send("speed2", F_SPEED, 1'b1, 1'b0);
    check_state("speed2", 2'd2, 1'b0, 16'h0002);
    check_pwm("pwm_lvl2", 4);
    send("speed3", F_SPEED, 1'b1, 1'b0);
    check_state("speed3", 2'd3, 1'b0, 16'h0003);
    check_pwm("pwm_lvl3", 8);
    send("speed1", F_SPEED, 1'b1, 1'b0);
    check_state("speed1", 2'd1, 1'b0, 16'h0001);
    check_pwm("pwm_lvl1_again", 2);

    // Rejected and unknown frames
    send("bad_check", F_BADCK, 1'b0, 1'b1);
    check_state("bad_check", 2'd1, 1'b0, 16'h0001);
    push("frame_error_one_cycle", 32'd0);
    @(negedge clk);
    check({31'd0, frame_error});
    send("bad_addr", F_BADAD, 1'b0, 1'b1);
    check_state("bad_addr", 2'd1, 1'b0, 16'h0001);
    send("unknown_cmd", F_UNKN, 1'b1, 1'b0);
    check_state("unknown_cmd", 2'd1, 1'b0, 16'h0001);

    // One-minute timer counting down to expiry
    send("timer1", F_TIMER, 1'b1, 1'b0);
    check_state("timer1", 2'd1, 1'b1, 16'h0100);
    repeat (9) @(negedge clk);
    push("before_tick", 32'h0100);
    check({16'd0, disp_value});
    @(negedge clk);
    push("first_tick", 32'h0059);
    check({16'd0, disp_value});
    repeat (100) @(negedge clk);
    push("eleven_ticks", 32'h0049);
    check({16'd0, disp_value});
    repeat (490) @(negedge clk);
    check_state("expired", 2'd0, 1'b0, 16'h0000);
    push("expired_pwm", 32'd0);
    check({31'd0, fan_pwm});
    check_pwm("expired_pwm_window", 0);

    // Preset stepping, SPEED ignored in OFF
    send("power_on2", F_POWER, 1'b1, 1'b0);
    send("preset1", F_TIMER, 1'b1, 1'b0);
    check_state("preset1", 2'd1, 1'b1, 16'h0100);
    send("preset2", F_TIMER, 1'b1, 1'b0);
    check_state("preset2", 2'd1, 1'b1, 16'h0300);
    send("preset3", F_TIMER, 1'b1, 1'b0);
    check_state("preset3", 2'd1, 1'b1, 16'h0500);
    send("preset0", F_TIMER, 1'b1, 1'b0);
    check_state("preset0", 2'd1, 1'b0, 16'h0001);
    send("power_off", F_POWER, 1'b1, 1'b0);
    check_state("power_off", 2'd0, 1'b0, 16'h0000);
    send("speed_in_off", F_SPEED, 1'b1, 1'b0);
    check_state("speed_in_off", 2'd0, 1'b0, 16'h0000);
    send("timer_in_off", F_TIMER, 1'b1, 1'b0);
    check_state("timer_in_off", 2'd0, 1'b0, 16'h0000);

    // POWER landing on the expiry edge
    send("power_on3", F_POWER, 1'b1, 1'b0);
    send("timer_a", F_TIMER, 1'b1, 1'b0);
    repeat (598) @(negedge clk);
    check_state("last_second_a", 2'd1, 1'b1, 16'h0001);
    send("power_on_expiry", F_POWER, 1'b1, 1'b0);
    check_state("power_on_expiry", 2'd0, 1'b0, 16'h0000);

    // SPEED landing on the expiry edge
    send("power_on4", F_POWER, 1'b1, 1'b0);
    send("timer_b", F_TIMER, 1'b1, 1'b0);
    repeat (598) @(negedge clk);
    check_state("last_second_b", 2'd1, 1'b1, 16'h0001);
    send("speed_on_expiry", F_SPEED, 1'b1, 1'b0);
    check_state("speed_on_expiry", 2'd0, 1'b0, 16'h0000);

    // Asynchronous reset while running at full drive
    send("power_on5", F_POWER, 1'b1, 1'b0);
    send("speed2b", F_SPEED, 1'b1, 1'b0);
    send("speed3b", F_SPEED, 1'b1, 1'b0);
    send("timer_c", F_TIMER, 1'b1, 1'b0);
    repeat (13) @(negedge clk);
    push("pwm_before_reset", 32'd1);
    check({31'd0, fan_pwm});
    #2 reset_p = 1'b1;
    #1;
    check_state("async_reset", 2'd0, 1'b0, 16'h0000);
    push("async_reset_pwm", 32'd0);
    check({31'd0, fan_pwm});
    @(negedge clk);
    reset_p = 1'b0;
    send("power_after_reset", F_POWER, 1'b1, 1'b0);
    check_state("power_after_reset", 2'd1, 1'b0, 16'h0001);
    check_pwm("pwm_after_reset", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
